spi_transmit: RTL and testbench
===============================

# spi_transmit

SPI master transmitter that serializes WIDTH-bit words from the FPGA fabric onto an SPI link toward the MCU. It drives SPI clock, chip select and serial data, mode 0, MSB first. It is the transmit-side counterpart of spiReceive, and a frame it produces is accepted unchanged by spiReceive. The block runs entirely on mainClk, and the SPI clock is derived from it by an integer divider.

## Interface

Parameters:
- WIDTH, 12, bits per frame.
- CLK_DIV, 4, SPI clock half-period in mainClk cycles; legal range ≥1.

Ports:
- mainClk  input  1  system clock. This is the only clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- txData  input  WIDTH  word to send; sampled only on handshake.
- txValid  input  1  producer has a word.
- txReady  output  1  block can accept a word. Held high only in IDLE.
- done  output  1  one-cycle pulse on the cycle cs deasserts after a completed frame.
- spiClk  output  1  SPI clock; idles low (CPOL=0).
- sdo  output  1  serial data, MSB first; changes only on spiClk falling edges (CPHA=0).
- cs  output  1  active-low chip select.

## Operation

- Handshake: a word is accepted on a mainClk edge where txValid && txReady. txData is copied into a shift register. txData and txValid are don't-care at all other times.
- States and transitions:
  - IDLE: txReady=1, cs=1, spiClk=0. On handshake, go to SETUP.
  - SETUP: cs=0, sdo=shift[WIDTH-1]. Stay H=CLK_DIV cycles, then go to SHIFT.
  - SHIFT: spiClk toggles every H cycles, starting with a rise, for exactly WIDTH rising and WIDTH falling edges.
    - On each falling edge except the last, the shift register shifts left by one and sdo takes the new MSB.
    - On the last falling edge, go to HOLD.
  - HOLD: spiClk=0, cs=0, sdo unchanged. After H cycles, set cs=1, pulse done, and go to GAP.
  - GAP: cs=1 for H cycles, then go to IDLE.
- Counters:
  - Divider counter: 0..CLK_DIV-1.
  - Bit counter: 0..WIDTH-1, counts falling edges. Its width is $clog2(WIDTH).
  - No wrap is visible outside the block; both counters clear on every state entry.
- Back-to-back: when txValid is held high, the next word is accepted on the first IDLE cycle. The minimum cs-high gap is therefore H+1 cycles.
- Reset, at any time including mid-frame, immediately forces these values:
  - spiClk=0, sdo=0, cs=1, txReady=1, done=0.
  - State IDLE, counters 0, shift register 0.
  - A partial frame is abandoned; it is never resumed.

## Timing

- Let H=CLK_DIV and let the handshake edge be cycle 0.
- Cycle 1: cs falls and sdo = bit WIDTH-1.
- spiClk rises at cycles 1+H+2Hk, for k=0..WIDTH-1.
- spiClk falls at cycles 1+2H+2Hk. sdo updates at the same falls, except the final one.
- cs rises and done=1 at cycle 1+2H·WIDTH+H.
- txReady rises at cycle 1+2H·WIDTH+2H.
- Data is stable for H cycles either side of every rising spiClk edge.
- Example, WIDTH=12 and H=2:
  - cs low at cycle 1.
  - Rises at 3,7,…,47; falls at 5,…,49.
  - cs high and done at 51; txReady at 53.
- txReady is combinational from state, so it reads 0 from cycle 1 onward.

## Test plan

- Single word: WIDTH=12, CLK_DIV=2, txData=12'hA5C pulsed with txValid at cycle 0.
  - sdo sampled on spiClk rises reads 1010_0101_1100.
  - Exactly 12 rises occur.
  - cs is low for cycles 1–50; done pulses at 51; txReady returns at 53.
- Data isolation: change txData to 12'hFFF and toggle txValid during a frame.
  - The transmitted bits are unaffected, and no second frame starts until txReady=1.
- Back-to-back: hold txValid=1 with words 12'h001 then 12'h800.
  - Two frames are sent, with a cs-high gap of exactly 3 cycles.
  - The bit patterns are exact, with the LSB and then the MSB isolated correctly.
- Reset mid-frame: assert reset asynchronously between mainClk edges after the 5th rising spiClk.
  - All outputs reach reset values without waiting for a clock edge.
  - After release, a new word 12'h3C3 transmits correctly from its MSB.
- Minimum divider: CLK_DIV=1, txData=12'h555.
  - spiClk toggles every cycle and the bits read alternating 0/1.
  - done pulses at cycle 26 and txReady rises at cycle 27.
- Loopback: connect spi_transmit to spiReceive #(12) on spiClk/sdo/cs and send 100 random words.
  - Each spiReceive writeEnable presents writeData equal to the sent word, in order.

Source files
------------

// File: rtl/spi_transmit.sv
// SPI mode-0 master transmitter: serializes WIDTH-bit words MSB first with cs framing.
// The SPI clock is derived from mainClk by an integer half-period divider.
module spi_transmit #(
    parameter int WIDTH   = 12,
    parameter int CLK_DIV = 4
) (
    input  logic             mainClk,
    input  logic             reset,
    input  logic [WIDTH-1:0] txData,
    input  logic             txValid,
    output logic             txReady,
    output logic             done,
    output logic             spiClk,
    output logic             sdo,
    output logic             cs
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state_r;
    logic [DIV_W-1:0] divCnt_r;
    logic [BIT_W-1:0] bitCnt_r;
    logic [WIDTH-1:0] shift_r;
    logic             spiClk_r;
    logic             sdo_r;
    logic             cs_r;
    logic             done_r;
    logic             divWrap_s;
    logic             lastBit_s;

    // End of the current half-period and last falling edge of the frame.
    always_comb begin
        divWrap_s = (divCnt_r == DIV_LAST);
        lastBit_s = (bitCnt_r == BIT_LAST);
    end

    // Frame sequencer: every state lasts whole half-periods; counters restart on each entry.
    always_ff @(posedge mainClk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            divCnt_r <= '0;
            bitCnt_r <= '0;
            shift_r  <= '0;
            spiClk_r <= 1'b0;
            sdo_r    <= 1'b0;
            cs_r     <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    divCnt_r <= '0;
                    bitCnt_r <= '0;
                    spiClk_r <= 1'b0;
                    cs_r     <= 1'b1;
                    if (txValid) begin
                        shift_r <= txData;
                        sdo_r   <= txData[WIDTH-1];
                        cs_r    <= 1'b0;
                        state_r <= SETUP;
                    end
                end
                SETUP: begin
                    if (divWrap_s) begin
                        divCnt_r <= '0;
                        spiClk_r <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        divCnt_r <= divCnt_r + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (divWrap_s) begin
                        divCnt_r <= '0;
                        if (spiClk_r) begin
                            spiClk_r <= 1'b0;
                            // The final fall leaves sdo on the LSB through HOLD.
                            if (lastBit_s) begin
                                bitCnt_r <= '0;
                                state_r  <= HOLD;
                            end else begin
                                bitCnt_r <= bitCnt_r + BIT_W'(1);
                                shift_r  <= {shift_r[WIDTH-2:0], 1'b0};
                                sdo_r    <= shift_r[WIDTH-2];
                            end
                        end else begin
                            spiClk_r <= 1'b1;
                        end
                    end else begin
                        divCnt_r <= divCnt_r + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (divWrap_s) begin
                        divCnt_r <= '0;
                        cs_r     <= 1'b1;
                        done_r   <= 1'b1;
                        state_r  <= GAP;
                    end else begin
                        divCnt_r <= divCnt_r + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (divWrap_s) begin
                        divCnt_r <= '0;
                        state_r  <= IDLE;
                    end else begin
                        divCnt_r <= divCnt_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    divCnt_r <= '0;
                    bitCnt_r <= '0;
                    spiClk_r <= 1'b0;
                    cs_r     <= 1'b1;
                end
            endcase
        end
    end

    assign txReady = (state_r == IDLE);
    assign done    = done_r;
    assign spiClk  = spiClk_r;
    assign sdo     = sdo_r;
    assign cs      = cs_r;

endmodule

// File: tb/tb_spi_transmit.sv
// Directed bench for spi_transmit: a slow (CLK_DIV=2) and a fast (CLK_DIV=1) instance,
// decoded by an inline mode-0 receiver that samples sdo on spiClk rises.
module tb_spi_transmit;

    logic        mainClk = 1'b0;
    logic        reset   = 1'b1;
    logic [11:0] txData0 = 12'h000, txData1 = 12'h000;
    logic        txValid0 = 1'b0, txValid1 = 1'b0;
    logic        txReady0, done0, spiClk0, sdo0, cs0;
    logic        txReady1, done1, spiClk1, sdo1, cs1;
    logic        fastSel = 1'b0;
    logic        monReady, monDone, monSpiClk, monSdo, monCs;
    int          checks = 0;
    int          errors = 0;

    always #5 mainClk = ~mainClk;

    spi_transmit #(.WIDTH(12), .CLK_DIV(2)) dut (
        .mainClk(mainClk), .reset(reset), .txData(txData0), .txValid(txValid0),
        .txReady(txReady0), .done(done0), .spiClk(spiClk0), .sdo(sdo0), .cs(cs0)
    );

    spi_transmit #(.WIDTH(12), .CLK_DIV(1)) dutFast (
        .mainClk(mainClk), .reset(reset), .txData(txData1), .txValid(txValid1),
        .txReady(txReady1), .done(done1), .spiClk(spiClk1), .sdo(sdo1), .cs(cs1)
    );

    assign monReady  = fastSel ? txReady1 : txReady0;
    assign monDone   = fastSel ? done1    : done0;
    assign monSpiClk = fastSel ? spiClk1  : spiClk0;
    assign monSdo    = fastSel ? sdo1     : sdo0;
    assign monCs     = fastSel ? cs1      : cs0;

    typedef struct {
        bit          fast;
        logic [11:0] data;
        logic [11:0] bits;
        int          doneCyc;
        int          readyCyc;
        bit          scramble;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic setValid(input bit fast, input logic v);
        if (fast) txValid1 = v;
        else      txValid0 = v;
    endtask

    // One frame: handshake on the posedge that ends the wait; cycle c is sampled at the c-th negedge after it.
    task automatic runFrame(input bit fast, input logic [11:0] data, input logic [11:0] expBits,
                            input int expDone, input int expReady, input bit scramble, input string name);
        logic [11:0] got;
        int rises, csFirst, csLast, csLowCnt, doneCyc, doneCnt, readyCyc, c, wt;
        logic prevClk;
        fastSel = fast;
        @(negedge mainClk);
        wt = 0;
        while (!monReady && wt < 300) begin
            @(negedge mainClk);
            wt++;
        end
        check(wt < 300, {name, "_wait_ready"}, wt, 0);
        if (fast) txData1 = data;
        else      txData0 = data;
        setValid(fast, 1'b1);
        @(posedge mainClk);
        got = 12'h000; rises = 0; csFirst = -1; csLast = -1; csLowCnt = 0;
        doneCyc = -1; doneCnt = 0; readyCyc = -1; c = 0; prevClk = 1'b0;
        while (readyCyc < 0 && c < 300) begin
            @(negedge mainClk);
            c++;
            if (c == 1) begin
                check(monReady == 1'b0, {name, "_ready_low_c1"}, int'(monReady), 0);
                setValid(fast, 1'b0);
                if (scramble) begin
                    if (fast) txData1 = 12'hFFF;
                    else      txData0 = 12'hFFF;
                end
            end
            if (scramble) setValid(fast, (c < expDone) ? logic'(c[0]) : 1'b0);
            if (monSpiClk && !prevClk) begin
                got = {got[10:0], monSdo};
                rises++;
            end
            prevClk = monSpiClk;
            if (!monCs) begin
                if (csFirst < 0) csFirst = c;
                csLast = c;
                csLowCnt++;
            end
            if (monDone) begin
                doneCnt++;
                doneCyc = c;
            end
            if (monReady) readyCyc = c;
        end
        setValid(fast, 1'b0);
        check(got == expBits,           {name, "_bits"},       int'(got), int'(expBits));
        check(rises == 12,              {name, "_rises"},      rises, 12);
        check(csFirst == 1,             {name, "_cs_fall"},    csFirst, 1);
        check(csLast == expDone - 1,    {name, "_cs_last"},    csLast, expDone - 1);
        check(csLowCnt == expDone - 1,  {name, "_cs_low_len"}, csLowCnt, expDone - 1);
        check(doneCyc == expDone,       {name, "_done_cyc"},   doneCyc, expDone);
        check(doneCnt == 1,             {name, "_done_cnt"},   doneCnt, 1);
        check(readyCyc == expReady,     {name, "_ready_cyc"},  readyCyc, expReady);
    endtask

    initial begin
        logic [11:0] frames[2];
        logic [11:0] sh;
        logic [11:0] w;
        logic prevClk, prevCs, prevReady;
        int frameCnt, gap, rises, c;
        bit gapDone;

        vecs[0] = '{fast: 1'b0, data: 12'hA5C, bits: 12'b1010_0101_1100, doneCyc: 51, readyCyc: 53, scramble: 1'b0};
        vecs[1] = '{fast: 1'b0, data: 12'h0F1, bits: 12'b0000_1111_0001, doneCyc: 51, readyCyc: 53, scramble: 1'b0};
        vecs[2] = '{fast: 1'b0, data: 12'h5A3, bits: 12'b0101_1010_0011, doneCyc: 51, readyCyc: 53, scramble: 1'b1};
        vecs[3] = '{fast: 1'b1, data: 12'h555, bits: 12'b0101_0101_0101, doneCyc: 26, readyCyc: 27, scramble: 1'b0};
        vecs[4] = '{fast: 1'b1, data: 12'hFFF, bits: 12'b1111_1111_1111, doneCyc: 26, readyCyc: 27, scramble: 1'b0};
        vecs[5] = '{fast: 1'b0, data: 12'h000, bits: 12'b0000_0000_0000, doneCyc: 51, readyCyc: 53, scramble: 1'b0};

        // Reset state of both instances.
        #12;
        check({txReady0, done0, spiClk0, sdo0, cs0} == 5'b10001, "reset_slow", int'({txReady0, done0, spiClk0, sdo0, cs0}), 5'b10001);
        check({txReady1, done1, spiClk1, sdo1, cs1} == 5'b10001, "reset_fast", int'({txReady1, done1, spiClk1, sdo1, cs1}), 5'b10001);
        @(negedge mainClk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            runFrame(vecs[i].fast, vecs[i].data, vecs[i].bits, vecs[i].doneCyc, vecs[i].readyCyc,
                     vecs[i].scramble, $sformatf("vec%0d", i));

        // Back-to-back: txValid held across the first IDLE cycle.
        fastSel = 1'b0;
        @(negedge mainClk);
        txData0 = 12'h001;
        txValid0 = 1'b1;
        @(posedge mainClk);
        frameCnt = 0; gap = 0; gapDone = 1'b0; sh = 12'h000; c = 0;
        prevClk = 1'b0; prevCs = 1'b0; prevReady = 1'b0;
        frames[0] = 12'h000; frames[1] = 12'h000;
        while (frameCnt < 2 && c < 300) begin
            @(negedge mainClk);
            c++;
            if (c == 1) txData0 = 12'h800;
            if (prevReady) txValid0 = 1'b0;
            prevReady = monReady;
            if (monSpiClk && !prevClk) sh = {sh[10:0], monSdo};
            prevClk = monSpiClk;
            if (monCs && !prevCs) begin
                frames[frameCnt] = sh;
                frameCnt++;
            end
            if (frameCnt == 1 && !gapDone) begin
                if (monCs) gap++;
                else gapDone = 1'b1;
            end
            prevCs = monCs;
        end
        txValid0 = 1'b0;
        check(frameCnt == 2,                   "b2b_frames", frameCnt, 2);
        check(frames[0] == 12'b0000_0000_0001, "b2b_word0",  int'(frames[0]), 12'h001);
        check(frames[1] == 12'b1000_0000_0000, "b2b_word1",  int'(frames[1]), 12'h800);
        check(gap == 3,                        "b2b_gap",    gap, 3);

        // Reset mid-frame, asserted between edges after the 5th spiClk rise.
        @(negedge mainClk);
        while (!txReady0) @(negedge mainClk);
        txData0 = 12'hFFF;
        txValid0 = 1'b1;
        @(posedge mainClk);
        rises = 0; prevClk = 1'b0; c = 0;
        while (rises < 5 && c < 100) begin
            @(negedge mainClk);
            c++;
            txValid0 = 1'b0;
            if (spiClk0 && !prevClk) rises++;
            prevClk = spiClk0;
        end
        check(rises == 5, "rst_reach_rise5", rises, 5);
        check({txReady0, spiClk0, sdo0, cs0} == 4'b0110, "rst_pre_state", int'({txReady0, spiClk0, sdo0, cs0}), 4'b0110);
        #1 reset = 1'b1;
        #1;
        check({txReady0, done0, spiClk0, sdo0, cs0} == 5'b10001, "rst_async", int'({txReady0, done0, spiClk0, sdo0, cs0}), 5'b10001);
        @(negedge mainClk);
        @(negedge mainClk);
        reset = 1'b0;
        check({txReady0, spiClk0, cs0} == 3'b101, "rst_released", int'({txReady0, spiClk0, cs0}), 3'b101);
        runFrame(1'b0, 12'h3C3, 12'b0011_1100_0011, 51, 53, 1'b0, "post_reset");

        // Loopback of random words through the receiver model.
        for (int i = 0; i < 100; i++) begin
            w = 12'($urandom);
            runFrame(1'b0, w, w, 51, 53, 1'b0, $sformatf("loop%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
